// File: rtl/cons_check_pipe.sv
// Two-stage pipelined checker evaluating NUM_CONS runtime-configured binary constraints per sample.
// Optional per-constraint fail counters are built when CONS_FAIL_CNT_EN is defined.
module cons_check_pipe #(
    parameter int NUM_VARS = 10,
    parameter int VAR_W    = 32,
    parameter int NUM_CONS = 10,
    parameter int SEL_W    = 4,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_VARS*VAR_W-1:0]   in_vars,
    input  logic [NUM_CONS*4-1:0]       cfg_op,
    input  logic [NUM_CONS*SEL_W-1:0]   cfg_sel_a,
    input  logic [NUM_CONS*SEL_W-1:0]   cfg_sel_b,
    input  logic [NUM_CONS-1:0]         cfg_use_imm,
    input  logic [NUM_CONS*VAR_W-1:0]   cfg_imm,
    input  logic [NUM_CONS-1:0]         cfg_inv_a,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_CONS-1:0]         out_cons,
    output logic                        out_pass,
    input  logic                        stat_clear,
    output logic [CNT_W-1:0]            stat_total,
    output logic [CNT_W-1:0]            stat_pass,
    output logic [NUM_CONS*CNT_W-1:0]   stat_fail
);

    typedef logic [VAR_W-1:0] lane_t;

    localparam logic [6:0] VAR_W_L = 7'(VAR_W);

    logic                s1_valid_r;
    lane_t               a_r  [NUM_CONS];
    lane_t               b_r  [NUM_CONS];
    logic [3:0]          op_r [NUM_CONS];
    lane_t               a_s  [NUM_CONS];
    lane_t               b_s  [NUM_CONS];
    logic [NUM_CONS-1:0] cons_s;
    logic                s2_adv_s;
    logic                in_fire_s;
    logic                out_fire_s;
    logic [CNT_W-1:0]    total_r;
    logic [CNT_W-1:0]    pass_r;

    // Out-of-range indices fall through every match and read as zero.
    function automatic lane_t pick_var(input logic [SEL_W-1:0] idx,
                                       input logic [NUM_VARS*VAR_W-1:0] vars);
        lane_t r;
        r = '0;
        for (int k = 0; k < NUM_VARS; k++) begin
            r = (idx == SEL_W'(k)) ? vars[k*VAR_W +: VAR_W] : r;
        end
        return r;
    endfunction

    function automatic logic eval_con(input logic [3:0] op, input lane_t a, input lane_t b);
        lane_t      sum_v;
        lane_t      prod_v;
        logic [5:0] sh_v;
        logic       r;
        sum_v  = a + b;
        prod_v = a * b;
        sh_v   = b[5:0];
        case (op)
            4'd0:    r = |(a | b);
            4'd1:    r = (a != b);
            4'd2:    r = (|a) && (|b);
            4'd3:    r = (|a) || (|b);
            4'd4:    r = ({1'b0, sh_v} >= VAR_W_L) ? 1'b0 : |(a >> sh_v);
            4'd5:    r = |sum_v;
            4'd6:    r = |prod_v;
            4'd7:    r = (a == b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign s2_adv_s   = !out_valid || out_ready;
    assign in_ready   = (!s1_valid_r || s2_adv_s) && !rst;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid && out_ready;
    assign stat_total = total_r;
    assign stat_pass  = pass_r;

    // Operand selection from the live sample and live configuration.
    always_comb begin
        for (int j = 0; j < NUM_CONS; j++) begin
            a_s[j] = pick_var(cfg_sel_a[j*SEL_W +: SEL_W], in_vars);
            a_s[j] = cfg_inv_a[j] ? ~a_s[j] : a_s[j];
            b_s[j] = cfg_use_imm[j] ? cfg_imm[j*VAR_W +: VAR_W]
                                    : pick_var(cfg_sel_b[j*SEL_W +: SEL_W], in_vars);
        end
    end

    // Stage 1 occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 1 operand/opcode capture; config is frozen here for the in-flight sample.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            for (int j = 0; j < NUM_CONS; j++) begin
                a_r[j]  <= a_s[j];
                b_r[j]  <= b_s[j];
                op_r[j] <= cfg_op[j*4 +: 4];
            end
        end
    end

    // Constraint evaluation on captured operands.
    always_comb begin
        cons_s = '0;
        for (int j = 0; j < NUM_CONS; j++) begin
            cons_s[j] = eval_con(op_r[j], a_r[j], b_r[j]);
        end
    end

    // Stage 2 result register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_cons  <= '0;
            out_pass  <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_cons <= cons_s;
                out_pass <= &cons_s;
            end
        end
    end

    // Saturating statistics; clear beats a same-cycle retire.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            total_r <= '0;
            pass_r  <= '0;
        end else if (out_fire_s) begin
            total_r <= sat_inc(total_r);
            if (out_pass) begin
                pass_r <= sat_inc(pass_r);
            end
        end
    end

`ifdef CONS_FAIL_CNT_EN
    logic [CNT_W-1:0] fail_r [NUM_CONS];

    // Per-constraint saturating fail counters.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_CONS; j++) begin
            if (rst || stat_clear) begin
                fail_r[j] <= '0;
            end else if (out_fire_s && !out_cons[j]) begin
                fail_r[j] <= sat_inc(fail_r[j]);
            end
        end
    end

    // Flatten fail counters onto the output bus.
    always_comb begin
        stat_fail = '0;
        for (int j = 0; j < NUM_CONS; j++) begin
            stat_fail[j*CNT_W +: CNT_W] = fail_r[j];
        end
    end
`else
    assign stat_fail = '0;
`endif

endmodule
